// File: rtl/downstream_oci_pipeline_tracker_pkg.sv
// Shared constants and stage record for the downstream OCI pipeline tracker.
// Optional feature macro used by the top: TIA_OCI_INFLIGHT_COUNT_EN.
package downstream_oci_pipeline_tracker_pkg;

    localparam int TIA_NUM_OUTPUT_CHANNELS = 4;
    localparam int TIA_OCI_WIDTH           = TIA_NUM_OUTPUT_CHANNELS;

    typedef struct packed {
        logic                     valid;
        logic [TIA_OCI_WIDTH-1:0] oci;
    } oci_stage_t;

    // True when more than one channel bit is set (x & (x-1) clears the lowest set bit).
    function automatic logic oci_multi_hot(input logic [TIA_OCI_WIDTH-1:0] oci);
        return (oci & (oci - TIA_OCI_WIDTH'(1))) != '0;
    endfunction

endpackage

// File: rtl/downstream_oci_pipeline_tracker_oci_pipeline_stage.sv
// One pipeline stage: valid bit plus OCI, with hold > clear > load priority.
// An invalid stage always carries oci = 0.
import downstream_oci_pipeline_tracker_pkg::*;

module oci_pipeline_stage (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_hold,
    input  logic                     i_clear,
    input  logic                     i_load,
    input  logic                     i_valid,
    input  logic [TIA_OCI_WIDTH-1:0] i_oci,
    output logic                     o_valid,
    output logic [TIA_OCI_WIDTH-1:0] o_oci
);

    oci_stage_t r_stage;
    oci_stage_t w_next;

    always_comb begin
        w_next = r_stage;
        if (!i_hold) begin
            if (i_clear) begin
                w_next = '0;
            end else if (i_load) begin
                w_next.valid = i_valid;
                w_next.oci   = i_valid ? i_oci : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
        end else begin
            r_stage <= w_next;
        end
    end

    assign o_valid = r_stage.valid;
    assign o_oci   = r_stage.oci;

endmodule

// File: rtl/downstream_oci_pipeline_tracker.sv
// Tracks the OCI of the three post-trigger pipeline stages and strobes enqueue at stage 3.
// Define TIA_OCI_INFLIGHT_COUNT_EN to add the per-channel in-flight counter output.
import downstream_oci_pipeline_tracker_pkg::*;

module downstream_oci_pipeline_tracker (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               issue_valid,
    input  logic [TIA_OCI_WIDTH-1:0]           issue_oci,
    input  logic                               halt,
    input  logic                               quash,
    output logic [TIA_OCI_WIDTH-1:0]           first_downstream_oci,
    output logic [TIA_OCI_WIDTH-1:0]           second_downstream_oci,
    output logic [TIA_OCI_WIDTH-1:0]           third_downstream_oci,
    output logic [TIA_NUM_OUTPUT_CHANNELS-1:0] output_channel_enqueue,
    output logic                               oci_error
`ifdef TIA_OCI_INFLIGHT_COUNT_EN
    ,
    output logic [TIA_NUM_OUTPUT_CHANNELS*2-1:0] inflight_count
`endif
);

    logic                     w_valid_1, w_valid_2, w_valid_3;
    logic [TIA_OCI_WIDTH-1:0] w_oci_1, w_oci_2, w_oci_3;
    logic                     r_oci_error;

    // Stage 1 is never quashed: it takes the new issue (or a bubble) on a quash edge.
    oci_pipeline_stage u_stage_1 (
        .clk     (clock),
        .rst_n   (reset_n),
        .i_hold  (halt),
        .i_clear (1'b0),
        .i_load  (1'b1),
        .i_valid (issue_valid),
        .i_oci   (issue_oci),
        .o_valid (w_valid_1),
        .o_oci   (w_oci_1)
    );

    oci_pipeline_stage u_stage_2 (
        .clk     (clock),
        .rst_n   (reset_n),
        .i_hold  (halt),
        .i_clear (quash),
        .i_load  (1'b1),
        .i_valid (w_valid_1),
        .i_oci   (w_oci_1),
        .o_valid (w_valid_2),
        .o_oci   (w_oci_2)
    );

    oci_pipeline_stage u_stage_3 (
        .clk     (clock),
        .rst_n   (reset_n),
        .i_hold  (halt),
        .i_clear (quash),
        .i_load  (1'b1),
        .i_valid (w_valid_2),
        .i_oci   (w_oci_2),
        .o_valid (w_valid_3),
        .o_oci   (w_oci_3)
    );

    assign first_downstream_oci   = w_valid_1 ? w_oci_1 : '0;
    assign second_downstream_oci  = w_valid_2 ? w_oci_2 : '0;
    assign third_downstream_oci   = w_valid_3 ? w_oci_3 : '0;
    // The stage-3 instruction retires on any non-halted edge, quash included.
    assign output_channel_enqueue = (w_valid_3 && !halt) ? w_oci_3 : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_oci_error <= 1'b0;
        end else if (issue_valid && !halt && oci_multi_hot(issue_oci)) begin
            r_oci_error <= 1'b1;
        end
    end

    assign oci_error = r_oci_error;

`ifdef TIA_OCI_INFLIGHT_COUNT_EN
    logic [TIA_NUM_OUTPUT_CHANNELS*2-1:0] r_inflight_count;
    logic [TIA_NUM_OUTPUT_CHANNELS*2-1:0] w_count_next;

    // Count from the contents the stages will hold after this edge; halt keeps the old count.
    always_comb begin
        w_count_next = r_inflight_count;
        if (!halt) begin
            for (int c = 0; c < TIA_NUM_OUTPUT_CHANNELS; c++) begin
                w_count_next[c*2 +: 2] = 2'(issue_valid & issue_oci[c])
                                       + 2'(!quash & w_valid_1 & w_oci_1[c])
                                       + 2'(!quash & w_valid_2 & w_oci_2[c]);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight_count <= '0;
        end else begin
            r_inflight_count <= w_count_next;
        end
    end

    assign inflight_count = r_inflight_count;
`endif

endmodule

// File: tb/tb_downstream_oci_pipeline_tracker.sv
// Directed bench for downstream_oci_pipeline_tracker; inputs change 1ns after the rising edge.
// Pipe observation packs {first, second, third, enqueue} as four hex nibbles.
import downstream_oci_pipeline_tracker_pkg::*;

module tb_downstream_oci_pipeline_tracker;

    localparam int W = TIA_OCI_WIDTH;

    logic                               clock = 1'b0;
    logic                               reset_n = 1'b0;
    logic                               issue_valid = 1'b0;
    logic [W-1:0]                       issue_oci = '0;
    logic                               halt = 1'b0;
    logic                               quash = 1'b0;
    logic [W-1:0]                       first_oci, second_oci, third_oci;
    logic [TIA_NUM_OUTPUT_CHANNELS-1:0] enq;
    logic                               oci_error;
`ifdef TIA_OCI_INFLIGHT_COUNT_EN
    logic [TIA_NUM_OUTPUT_CHANNELS*2-1:0] inflight_count;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    logic [4*W-1:0] obs;

    assign obs = {first_oci, second_oci, third_oci, enq};

    downstream_oci_pipeline_tracker dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .issue_valid            (issue_valid),
        .issue_oci              (issue_oci),
        .halt                   (halt),
        .quash                  (quash),
        .first_downstream_oci   (first_oci),
        .second_downstream_oci  (second_oci),
        .third_downstream_oci   (third_oci),
        .output_channel_enqueue (enq),
        .oci_error              (oci_error)
`ifdef TIA_OCI_INFLIGHT_COUNT_EN
        ,
        .inflight_count         (inflight_count)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] o, input logic h, input logic q);
        issue_valid = v;
        issue_oci   = o;
        halt        = h;
        quash       = q;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, '0, 1'b0, 1'b0);
        step();
        tests_run++;
        if (obs !== 16'h0000 || oci_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_held: pipe=%h err=%b expected pipe=0000 err=0", obs, oci_error);
        end
        reset_n = 1'b1;
        step();
        step();
        tests_run++;
        if (obs !== 16'h0000 || oci_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_released: pipe=%h err=%b expected pipe=0000 err=0", obs, oci_error);
        end
    endtask

    task automatic test_single_issue();
        logic [4*W-1:0] exp_pipe [4];
        exp_pipe = '{16'h4000, 16'h0400, 16'h0044, 16'h0000};
        drive(1'b1, 4'b0100, 1'b0, 1'b0);
        tests_run++;
        if (obs !== 16'h0000) begin
            tests_failed++;
            $display("FAIL single_pre_edge: pipe=%h expected 0000", obs);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            drive(1'b0, '0, 1'b0, 1'b0);
            tests_run++;
            if (obs !== exp_pipe[i]) begin
                tests_failed++;
                $display("FAIL single_plus%0d: pipe=%h expected %h", i + 1, obs, exp_pipe[i]);
            end
        end
    endtask

    task automatic test_halt();
        drive(1'b1, 4'b0001, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'b0010, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'b1000, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b1, 1'b0);
        tests_run++;
        if (obs !== 16'h8210) begin
            tests_failed++;
            $display("FAIL halt_enter: pipe=%h expected 8210", obs);
        end
        step();
        // Issue and quash during halt must both be ignored, including a multi-hot OCI.
        drive(1'b1, 4'b0110, 1'b1, 1'b1);
        tests_run++;
        if (obs !== 16'h8210) begin
            tests_failed++;
            $display("FAIL halt_cycle1: pipe=%h expected 8210", obs);
        end
        step();
        drive(1'b0, '0, 1'b1, 1'b0);
        tests_run++;
        if (obs !== 16'h8210 || oci_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt_cycle2: pipe=%h err=%b expected 8210 err=0", obs, oci_error);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        tests_run++;
        if (obs !== 16'h8211) begin
            tests_failed++;
            $display("FAIL halt_release_enq: pipe=%h expected 8211", obs);
        end
        step();
        tests_run++;
        if (obs !== 16'h0822) begin
            tests_failed++;
            $display("FAIL halt_after1: pipe=%h expected 0822", obs);
        end
        step();
        step();
        tests_run++;
        if (obs !== 16'h0000) begin
            tests_failed++;
            $display("FAIL halt_drained: pipe=%h expected 0000", obs);
        end
    endtask

    task automatic test_quash();
        drive(1'b1, 4'b0100, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'b0010, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'b0001, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'b1000, 1'b0, 1'b1);
        tests_run++;
        if (obs !== 16'h1244) begin
            tests_failed++;
            $display("FAIL quash_cycle: pipe=%h expected 1244", obs);
        end
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        tests_run++;
        if (obs !== 16'h8000) begin
            tests_failed++;
            $display("FAIL quash_after1: pipe=%h expected 8000", obs);
        end
        step();
        tests_run++;
        if (obs !== 16'h0800) begin
            tests_failed++;
            $display("FAIL quash_after2: pipe=%h expected 0800", obs);
        end
        step();
        tests_run++;
        if (obs !== 16'h0088) begin
            tests_failed++;
            $display("FAIL quash_after3: pipe=%h expected 0088", obs);
        end
        step();
    endtask

    task automatic test_oci_error();
        tests_run++;
        if (oci_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL error_clear_before: err=%b expected 0", oci_error);
        end
        drive(1'b1, 4'b0110, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        tests_run++;
        if (oci_error !== 1'b1 || obs !== 16'h6000) begin
            tests_failed++;
            $display("FAIL error_set: pipe=%h err=%b expected 6000 err=1", obs, oci_error);
        end
        step();
        step();
        tests_run++;
        if (obs !== 16'h0066) begin
            tests_failed++;
            $display("FAIL error_tracked: pipe=%h expected 0066", obs);
        end
        step();
        step();
        tests_run++;
        if (oci_error !== 1'b1 || obs !== 16'h0000) begin
            tests_failed++;
            $display("FAIL error_sticky: pipe=%h err=%b expected 0000 err=1", obs, oci_error);
        end
    endtask

    task automatic test_reset_mid_run();
        drive(1'b1, 4'b0010, 1'b0, 1'b0);
        step();
        step();
        step();
        tests_run++;
        if (obs !== 16'h2222) begin
            tests_failed++;
            $display("FAIL midrun_full: pipe=%h expected 2222", obs);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (obs !== 16'h0000 || oci_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrun_async: pipe=%h err=%b expected 0000 err=0", obs, oci_error);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        step();
        reset_n = 1'b1;
        step();
        step();
        tests_run++;
        if (obs !== 16'h0000 || oci_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrun_after: pipe=%h err=%b expected 0000 err=0", obs, oci_error);
        end
    endtask

`ifdef TIA_OCI_INFLIGHT_COUNT_EN
    task automatic test_inflight_count();
        logic [7:0] exp_cnt [4];
        exp_cnt = '{8'h01, 8'h02, 8'h03, 8'h03};
        tests_run++;
        if (inflight_count !== 8'h00) begin
            tests_failed++;
            $display("FAIL inflight_empty: count=%h expected 00", inflight_count);
        end
        drive(1'b1, 4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            tests_run++;
            if (inflight_count !== exp_cnt[i]) begin
                tests_failed++;
                $display("FAIL inflight_edge%0d: count=%h expected %h", i + 1, inflight_count, exp_cnt[i]);
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        step();
        step();
        step();
        tests_run++;
        if (inflight_count !== 8'h00) begin
            tests_failed++;
            $display("FAIL inflight_drained: count=%h expected 00", inflight_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_issue();
        test_halt();
        test_quash();
        test_oci_error();
        test_reset_mid_run();
`ifdef TIA_OCI_INFLIGHT_COUNT_EN
        test_inflight_count();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
